traffic_light_monitor: RTL and testbench

//  Safety monitor directly downstream of the traffic light controller. Consumes its six

---
 rtl/traffic_light_monitor.sv | 147 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: safety monitor between the traffic light controller and the lamps.
// Checks lamp pattern legality, phase order and phase durations (in ticks), passes the
// controller's lamps through while healthy, and latches a fault code with flashing all-red
// on any violation until reset.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   tick                     one-cycle timing pulse shared with the controller
//   ns_g/ns_y/ns_r           controller NS lamp requests
//   ew_g/ew_y/ew_r           controller EW lamp requests
//   lamp_ns_*/lamp_ew_*      registered lamp drive
//   fault                    sticky fault flag
//   fault_code               0 none, 1 bad pattern, 2 bad order, 3 too long, 4 too short
module traffic_light_monitor #(
    parameter int DUR_NS_G    = 5,
    parameter int DUR_NS_Y    = 2,
    parameter int DUR_EW_G    = 5,
    parameter int DUR_EW_Y    = 2,
    parameter int FLASH_TICKS = 1,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ns_g,
    input  logic       ns_y,
    input  logic       ns_r,
    input  logic       ew_g,
    input  logic       ew_y,
    input  logic       ew_r,
    output logic       lamp_ns_g,
    output logic       lamp_ns_y,
    output logic       lamp_ns_r,
    output logic       lamp_ew_g,
    output logic       lamp_ew_y,
    output logic       lamp_ew_r,
    output logic       fault,
    output logic [2:0] fault_code
);
    localparam int FC_W = $clog2(FLASH_TICKS + 1);
    localparam logic [5:0] ALL_RED = 6'b001001;

    typedef enum logic [1:0] {SYNC, RUN, FAULT} mon_t;
    typedef enum logic [2:0] {PH_NS_G, PH_NS_Y, PH_EW_G, PH_EW_Y, PH_ILL} phase_t;

    mon_t             state, state_n;
    phase_t           prev, prev_n, phase, succ;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_sat;
    logic [CNT_W:0]   sum, dur_q;
    logic [FC_W-1:0]  fcnt, fcnt_n;
    logic             flash, flash_n, fault_n;
    logic [5:0]       in_v, lamps, lamps_n;
    logic [2:0]       code_n, err;

    // bit order {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
    assign in_v = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};
    assign phase = in_v == 6'b100001 ? PH_NS_G :
                   in_v == 6'b010001 ? PH_NS_Y :
                   in_v == 6'b001100 ? PH_EW_G :
                   in_v == 6'b001010 ? PH_EW_Y : PH_ILL;
    assign succ  = prev == PH_EW_Y ? PH_NS_G : phase_t'(prev + 3'd1);
    assign dur_q = prev == PH_NS_G ? (CNT_W+1)'(DUR_NS_G) :
                   prev == PH_NS_Y ? (CNT_W+1)'(DUR_NS_Y) :
                   prev == PH_EW_G ? (CNT_W+1)'(DUR_EW_G) : (CNT_W+1)'(DUR_EW_Y);
    // extra bit lets the "too long" compare see cnt+tick before saturation
    assign sum     = {1'b0, cnt} + (CNT_W+1)'(tick);
    assign cnt_sat = &cnt ? cnt : sum[CNT_W-1:0];

    always_comb begin
        state_n = state;
        prev_n  = prev;
        cnt_n   = cnt;
        fcnt_n  = fcnt;
        flash_n = flash;
        lamps_n = lamps;
        fault_n = fault;
        code_n  = fault_code;
        err     = 3'd0;
        unique case (state)
            SYNC: begin
                if (phase == PH_ILL) err = 3'd1;
                else if (phase == PH_NS_G) begin
                    state_n = RUN;
                    prev_n  = PH_NS_G;
                    cnt_n   = CNT_W'(tick);
                    lamps_n = in_v;
                end else lamps_n = ALL_RED;
            end
            RUN: begin
                if (phase == PH_ILL) err = 3'd1;
                else if (phase == prev) begin
                    if (sum > dur_q) err = 3'd3;
                    else begin
                        cnt_n   = cnt_sat;
                        lamps_n = in_v;
                    end
                end else if (phase != succ) err = 3'd2;
                else if ({1'b0, cnt} != dur_q) err = 3'd4;
                else begin
                    // the tick sampled on the change edge belongs to the new phase
                    prev_n  = phase;
                    cnt_n   = CNT_W'(tick);
                    lamps_n = in_v;
                end
            end
            FAULT: begin
                if (tick) begin
                    fcnt_n  = fcnt == FC_W'(FLASH_TICKS - 1) ? '0 : fcnt + FC_W'(1);
                    flash_n = fcnt == FC_W'(FLASH_TICKS - 1) ? ~flash : flash;
                end
                lamps_n = {2'b00, flash_n, 2'b00, flash_n};
            end
            default: state_n = SYNC;
        endcase
        if (err != 3'd0) begin
            state_n = FAULT;
            fault_n = 1'b1;
            code_n  = err;
            flash_n = 1'b1;
            fcnt_n  = '0;
            lamps_n = ALL_RED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SYNC;
            prev       <= PH_NS_G;
            cnt        <= '0;
            fcnt       <= '0;
            flash      <= 1'b1;
            lamps      <= ALL_RED;
            fault      <= 1'b0;
            fault_code <= 3'd0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            cnt        <= cnt_n;
            fcnt       <= fcnt_n;
            flash      <= flash_n;
            lamps      <= lamps_n;
            fault      <= fault_n;
            fault_code <= code_n;
        end
    end

    assign {lamp_ns_g, lamp_ns_y, lamp_ns_r, lamp_ew_g, lamp_ew_y, lamp_ew_r} = lamps;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: randomized directed checks of traffic_light_monitor against a phase-level model.
module tb_traffic_light_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [5:0] vin = 6'b001001;
    logic       lamp_ns_g, lamp_ns_y, lamp_ns_r, lamp_ew_g, lamp_ew_y, lamp_ew_r;
    logic       fault;
    logic [2:0] fault_code;

    logic [5:0] pat [4];
    int         dur [4];
    logic [5:0] all_red;
    int         vectors = 0;
    int         miscompares = 0;
    int         gcyc = 0;
    int         per = 4;

    // model: 0 sync, 1 run, 2 fault
    int         m_mode, m_prev, m_cnt;
    bit         m_flash, m_fault;
    logic [5:0] m_lamps;
    logic [2:0] m_code;

    always #5 clk = ~clk;

    traffic_light_monitor dut (
        .clk(clk), .rst(rst), .tick(tick),
        .ns_g(vin[5]), .ns_y(vin[4]), .ns_r(vin[3]),
        .ew_g(vin[2]), .ew_y(vin[1]), .ew_r(vin[0]),
        .lamp_ns_g(lamp_ns_g), .lamp_ns_y(lamp_ns_y), .lamp_ns_r(lamp_ns_r),
        .lamp_ew_g(lamp_ew_g), .lamp_ew_y(lamp_ew_y), .lamp_ew_r(lamp_ew_r),
        .fault(fault), .fault_code(fault_code)
    );

    task automatic trip(input int c);
        m_mode  = 2;
        m_fault = 1'b1;
        m_code  = 3'(c);
        m_flash = 1'b1;
        m_lamps = all_red;
    endtask

    task automatic model(input logic [5:0] v, input bit t, input bit r);
        int p;
        p = -1;
        for (int i = 0; i < 4; i++) if (v === pat[i]) p = i;
        if (r) begin
            m_mode = 0; m_prev = 0; m_cnt = 0; m_flash = 1'b1;
            m_fault = 1'b0; m_code = 3'd0; m_lamps = all_red;
        end else if (m_mode == 0) begin
            if (p < 0) trip(1);
            else if (p == 0) begin m_mode = 1; m_prev = 0; m_cnt = int'(t); m_lamps = v; end
            else m_lamps = all_red;
        end else if (m_mode == 1) begin
            if (p < 0) trip(1);
            else if (p == m_prev) begin
                if (m_cnt + int'(t) > dur[m_prev]) trip(3);
                else begin m_cnt += int'(t); m_lamps = v; end
            end else if (p != (m_prev + 1) % 4) trip(2);
            else if (m_cnt != dur[m_prev]) trip(4);
            else begin m_prev = p; m_cnt = int'(t); m_lamps = v; end
        end else begin
            if (t) m_flash = ~m_flash;
            m_lamps = m_flash ? all_red : 6'b000000;
        end
    endtask

    function automatic bit tick_now();
        return (gcyc % per) == 0;
    endfunction

    task automatic step(input logic [5:0] v, input bit t, input bit r);
        logic [5:0] got;
        vin = v; tick = t; rst = r;
        model(v, t, r);
        @(posedge clk);
        #1;
        vectors++;
        gcyc++;
        got = {lamp_ns_g, lamp_ns_y, lamp_ns_r, lamp_ew_g, lamp_ew_y, lamp_ew_r};
        assert (got === m_lamps) else begin
            miscompares++;
            $error("FAIL lamps cyc=%0d got=%b exp=%b", gcyc, got, m_lamps);
        end
        assert (fault === m_fault) else begin
            miscompares++;
            $error("FAIL fault cyc=%0d got=%b exp=%b", gcyc, fault, m_fault);
        end
        assert (fault_code === m_code) else begin
            miscompares++;
            $error("FAIL code cyc=%0d got=%0d exp=%0d", gcyc, fault_code, m_code);
        end
    endtask

    task automatic do_reset();
        step(all_red, 1'b0, 1'b1);
        step(all_red, 1'b0, 1'b1);
    endtask

    // hold one pattern until nt ticks were applied with it, then pad with tick-free
    // cycles; align pads right up to the next tick so the change edge carries a tick
    task automatic drive_phase(input logic [5:0] v, input int nt, input bit align);
        int seen, x;
        bit t;
        seen = 0;
        while (seen < nt) begin
            t = tick_now();
            step(v, t, 1'b0);
            seen += int'(t);
        end
        x = align ? per : $urandom_range(0, per - 1);
        while (x > 0 && !tick_now()) begin
            step(v, 1'b0, 1'b0);
            x--;
        end
    endtask

    task automatic hold(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) step(v, tick_now(), 1'b0);
    endtask

    initial begin
        pat[0] = 6'b100001; pat[1] = 6'b010001; pat[2] = 6'b001100; pat[3] = 6'b001010;
        dur[0] = 5; dur[1] = 2; dur[2] = 5; dur[3] = 2;
        all_red = 6'b001001;

        // compliant controller, tick every 4 clocks, two full cycles
        per = 4; gcyc = 0;
        do_reset();
        for (int c = 0; c < 2; c++)
            for (int p = 0; p < 4; p++) drive_phase(pat[p], dur[p], 1'b0);
        drive_phase(pat[0], 2, 1'b0);

        // illegal pattern in RUN, then flashing red
        hold(6'b100100, 1);
        hold(6'b100100, 3 * per);

        // wrong order after full NS green
        per = $urandom_range(2, 5); gcyc = 0;
        do_reset();
        drive_phase(pat[0], 5, 1'b0);
        hold(pat[2], 2 * per);

        // NS green too long
        do_reset();
        drive_phase(pat[0], 6, 1'b0);
        hold(pat[0], per);

        // NS green too short
        do_reset();
        drive_phase(pat[0], 3, 1'b0);
        hold(pat[1], 2 * per);

        // reset out of FAULT, resync, change edges carrying ticks
        per = 3; gcyc = 1;
        step(pat[1], 1'b0, 1'b1);
        hold(pat[3], 2);
        for (int p = 0; p < 4; p++) drive_phase(pat[p], dur[p], 1'b1);
        drive_phase(pat[0], dur[0], 1'b1);

        // random trials with occasional duration slips and corrupted patterns
        for (int k = 0; k < 12; k++) begin
            per = $urandom_range(2, 5); gcyc = $urandom_range(0, 4);
            do_reset();
            hold(pat[$urandom_range(1, 3)], $urandom_range(0, 3));
            for (int n = 0; n < int'($urandom_range(1, 7)); n++) begin
                int p, nt;
                p  = n % 4;
                nt = dur[p];
                if ($urandom_range(0, 5) == 0) nt = nt + ($urandom_range(0, 1) == 1 ? 1 : -1);
                drive_phase(pat[p], nt, $urandom_range(0, 1) == 1);
            end
            if ($urandom_range(0, 1) == 1) hold(6'($urandom_range(0, 63)), 1);
            hold(pat[$urandom_range(0, 3)], $urandom_range(1, 2 * per));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
